// File: rtl/key_entry.sv
// Keypad entry buffer: collects BCD digits, supports backspace/clear,
// commits the buffer to `value` on enter, and flags rejected keys.
module key_entry #(
    parameter int NDIG = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        num,
    input  logic              key_stb,
    output logic [4*NDIG-1:0] disp,
    output logic [3:0]        cnt,
    output logic [4*NDIG-1:0] value,
    output logic              value_vld,
    output logic              err,
    output logic [1:0]        state
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ENTRY = 2'd1,
        SHOWN = 2'd2
    } state_t;

    localparam logic [3:0] MAX_CNT = 4'(NDIG);

    localparam logic [3:0] KEY_BSP   = 4'hA;
    localparam logic [3:0] KEY_CLR   = 4'hB;
    localparam logic [3:0] KEY_ENTER = 4'hC;

    state_t              state_q, state_n;
    logic [4*NDIG-1:0]   disp_q, disp_n;
    logic [3:0]          cnt_q, cnt_n;
    logic [4*NDIG-1:0]   value_q, value_n;
    logic                vld_q, vld_n;
    logic                err_q, err_n;
    logic                is_digit;

    assign is_digit = (num <= 4'd9);

    // Register all state and the one-cycle pulse outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            disp_q  <= '0;
            cnt_q   <= '0;
            value_q <= '0;
            vld_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_n;
            disp_q  <= disp_n;
            cnt_q   <= cnt_n;
            value_q <= value_n;
            vld_q   <= vld_n;
            err_q   <= err_n;
        end
    end

    // Next-state and datapath decode of the strobed key.
    always_comb begin
        state_n = state_q;
        disp_n  = disp_q;
        cnt_n   = cnt_q;
        value_n = value_q;
        vld_n   = 1'b0;
        err_n   = 1'b0;

        if (state_q != EMPTY && state_q != ENTRY && state_q != SHOWN) begin
            // Illegal code recovers unconditionally, strobe or not.
            state_n = EMPTY;
            disp_n  = '0;
            cnt_n   = '0;
        end else if (key_stb) begin
            if (num == KEY_CLR) begin
                state_n = EMPTY;
                disp_n  = '0;
                cnt_n   = '0;
            end else if (is_digit) begin
                if (state_q == ENTRY) begin
                    if (cnt_q < MAX_CNT) begin
                        disp_n = {disp_q[4*NDIG-5:0], num};
                        cnt_n  = cnt_q + 4'd1;
                    end else begin
                        err_n = 1'b1;
                    end
                end else begin
                    disp_n  = {{(4*NDIG-4){1'b0}}, num};
                    cnt_n   = 4'd1;
                    state_n = ENTRY;
                end
            end else if (num == KEY_BSP) begin
                case (state_q)
                    ENTRY: begin
                        disp_n = disp_q >> 4;
                        cnt_n  = cnt_q - 4'd1;
                        if (cnt_q == 4'd1) state_n = EMPTY;
                    end
                    SHOWN: begin
                        disp_n  = '0;
                        cnt_n   = '0;
                        state_n = EMPTY;
                    end
                    default: err_n = 1'b1;
                endcase
            end else if (num == KEY_ENTER) begin
                if (state_q == EMPTY) begin
                    err_n = 1'b1;
                end else begin
                    value_n = disp_q;
                    vld_n   = 1'b1;
                    state_n = SHOWN;
                end
            end else begin
                err_n = 1'b1;
            end
        end
    end

    assign disp      = disp_q;
    assign cnt       = cnt_q;
    assign value     = value_q;
    assign value_vld = vld_q;
    assign err       = err_q;
    assign state     = state_q;

endmodule

// File: doc/key_entry.md
KEY_ENTRY -- requirements
Module: key_entry

Interface
REQ-001 Parameter: NDIG, 4, number of BCD digits held in the entry buffer (legal range 2..8).
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 num  input  4  key code from keypad encoder; sampled only when key_stb high.
REQ-005 key_stb  input  1  one-cycle key-press strobe from keypad debouncer.
REQ-006 disp  output  4*NDIG  live entry buffer, BCD; newest digit in bits [3:0].
REQ-007 cnt  output  4  number of digits currently entered (0..NDIG).
REQ-008 value  output  4*NDIG  last committed BCD number.
REQ-009 value_vld  output  1  one-cycle pulse, high in the cycle value takes a new commit.
REQ-010 err  output  1  one-cycle pulse on a rejected key.
REQ-011 state  output  2  FSM state code: EMPTY=0, ENTRY=1, SHOWN=2.

Function
REQ-012 Key decode SHALL be: 0x0-0x9 digit, 0xA backspace, 0xB clear, 0xC enter, 0xD-0xF invalid.
REQ-013 All outputs SHALL be registered and update on the clk edge that samples key_stb high; key_stb low SHALL leave all state unchanged and num ignored.
REQ-014 value_vld and err SHALL each be high for exactly one cycle per triggering strobe; back-to-back strobes on consecutive cycles SHALL each be processed.
REQ-015 EMPTY + digit d: disp = d zero-extended, cnt=1, go ENTRY (digit 0 accepted as a digit).
REQ-016 ENTRY + digit d with cnt<NDIG: disp shifted left 4 bits, d inserted in [3:0], cnt+1.
REQ-017 ENTRY + digit with cnt==NDIG: err pulse, disp and cnt unchanged.
REQ-018 ENTRY + backspace: disp shifted right 4 bits with zero fill at top, cnt-1; if cnt reaches 0 go EMPTY.
REQ-019 EMPTY + backspace: err pulse, no change.
REQ-020 Clear in any state: disp=0, cnt=0, go EMPTY, no err; value unchanged.
REQ-021 ENTRY + enter: value=disp, value_vld pulse, disp and cnt held, go SHOWN.
REQ-022 EMPTY + enter: err pulse, value unchanged, no value_vld.
REQ-023 SHOWN + digit d: disp = d, cnt=1, go ENTRY; value unchanged.
REQ-024 SHOWN + backspace: disp=0, cnt=0, go EMPTY, no err.
REQ-025 SHOWN + enter: value rewritten with disp (same value), value_vld pulses again, stay SHOWN.
REQ-026 Invalid key (0xD-0xF) in any state: err pulse, no other change.
REQ-027 err and value_vld SHALL never be high in the same cycle.
REQ-028 Illegal state code 3 SHALL recover to EMPTY with disp=0, cnt=0 on the next edge, regardless of key_stb.

Reset
REQ-029 rst_n low SHALL immediately, without clock, force disp=0, cnt=0, value=0, value_vld=0, err=0, state=EMPTY.
REQ-030 A key_stb on an edge where rst_n is low SHALL be ignored; first processed strobe is on the first edge with rst_n high.
REQ-031 Reset asserted mid-entry SHALL discard the partial entry and the committed value.

Verification (NDIG=4)
REQ-032 Reset, keys 1,2,3,C -> disp=0x0123, cnt=3, value=0x0123, value_vld one pulse, state=2.
REQ-033 Keys 1,2,3,4,5 -> on 5: err one pulse, disp=0x1234, cnt=4, state=1.
REQ-034 Keys 7,8,A,A,A -> after 2nd A: disp=0, cnt=0, state=0; 3rd A: err pulse.
REQ-035 From reset, C then E -> err pulse on each, value=0, value_vld never high.
REQ-036 From SHOWN with value=0x0123, key 9 -> disp=0x0009, cnt=1, state=1, value still 0x0123; then B -> disp=0, state=0, no err.
REQ-037 Keys 4,5 then rst_n low between edges -> all outputs 0 before next clk edge; key 6 strobed during reset ignored.
